riscv_instr_aligner: RTL and testbench

//  Stage between prefetch buffer and compressed decoder. Turns the stream of word-aligned
//  32-bit fetch words into one instruction per handshake, aligned to the current PC.

---
 rtl/riscv_instr_aligner.sv | 136 +++++++++++++
 tb/tb_riscv_instr_aligner.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_instr_aligner.sv
// Instruction aligner between the prefetch buffer and the compressed decoder: turns word-aligned
// fetch words into one PC-aligned instruction per handshake, joining straddling 32-bit instructions.
//
// state         | meaning
// ALIGNED       | pc[1]=0, no residual; next instruction starts in the low half of the fetch word
// MISALIGNED    | pc[1]=1, residual holds the halfword at pc
// BR_MISALIGNED | pc[1]=1 after a redirect, residual empty; low half of the next word is skipped
module riscv_instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_ready_i
);

    typedef enum logic [1:0] {
        ALIGNED       = 2'd0,
        MISALIGNED    = 2'd1,
        BR_MISALIGNED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] res_q, res_d;

    logic [15:0] word_lo;
    logic [15:0] word_hi;
    logic        word_lo_is_32;
    logic        res_is_32;
    logic        word_accept;
    logic [31:0] pc_plus2;
    logic [31:0] pc_plus4;
    logic [31:0] branch_pc;
    logic        branch_to_odd_half;

    assign word_lo            = fetch_rdata_i[15:0];
    assign word_hi            = fetch_rdata_i[31:16];
    assign word_lo_is_32      = (word_lo[1:0] == 2'b11);
    assign res_is_32          = (res_q[1:0] == 2'b11);
    assign word_accept        = fetch_valid_i && instr_ready_i;
    assign pc_plus2           = pc_q + 32'd2;
    assign pc_plus4           = pc_q + 32'd4;
    assign branch_pc          = branch_addr_i & 32'hFFFF_FFFE;
    assign branch_to_odd_half = branch_pc[1];

    assign instr_addr_o = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALIGNED;
            pc_q    <= RESET_PC;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        res_d         = res_q;
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_rdata_o = {16'h0000, word_lo};

        if (!rst) begin
            if (branch_i) begin
                // Redirect: the word in flight belongs to the old stream and is dropped.
                fetch_ready_o = 1'b1;
                pc_d          = branch_pc;
                res_d         = 16'h0000;
                state_d       = branch_to_odd_half ? BR_MISALIGNED : ALIGNED;
            end else begin
                case (state_q)
                    ALIGNED: begin
                        instr_valid_o = fetch_valid_i;
                        fetch_ready_o = instr_ready_i;
                        if (word_lo_is_32) begin
                            instr_rdata_o = fetch_rdata_i;
                            if (word_accept) begin
                                pc_d = pc_plus4;
                            end
                        end else begin
                            instr_rdata_o = {16'h0000, word_lo};
                            if (word_accept) begin
                                res_d   = word_hi;
                                pc_d    = pc_plus2;
                                state_d = MISALIGNED;
                            end
                        end
                    end
                    MISALIGNED: begin
                        if (res_is_32) begin
                            // Upper half of the straddling instruction comes from the new word.
                            instr_valid_o = fetch_valid_i;
                            fetch_ready_o = instr_ready_i;
                            instr_rdata_o = {word_lo, res_q};
                            if (word_accept) begin
                                res_d = word_hi;
                                pc_d  = pc_plus4;
                            end
                        end else begin
                            instr_valid_o = 1'b1;
                            instr_rdata_o = {16'h0000, res_q};
                            if (instr_ready_i) begin
                                pc_d    = pc_plus2;
                                state_d = ALIGNED;
                            end
                        end
                    end
                    BR_MISALIGNED: begin
                        fetch_ready_o = 1'b1;
                        if (fetch_valid_i) begin
                            res_d   = word_hi;
                            state_d = MISALIGNED;
                        end
                    end
                    default: begin
                        state_d = ALIGNED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Bench for riscv_instr_aligner: a halfword-memory model of the program predicts every output
// instruction from the PC alone; directed scenarios pin the model with literal expectations.
module tb_riscv_instr_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        instr_ready_i;

    always #5 clk = ~clk;

    riscv_instr_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_rdata_i (fetch_rdata_i),
        .fetch_ready_o (fetch_ready_o),
        .instr_valid_o (instr_valid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_addr_o  (instr_addr_o),
        .instr_ready_i (instr_ready_i)
    );

    int checks = 0;
    int errors = 0;

    // Program memory seen by the fetch side; 1 KiB window, addresses wrap onto it.
    logic [31:0] mem [0:255];
    logic [31:0] mpc   = RESET_PC;
    logic [31:0] faddr = RESET_PC;
    bit          started = 1'b0;
    bit          gap_en  = 1'b0;

    int          acc_n = 0;
    logic [31:0] acc_addr [$];
    logic [31:0] acc_data [$];
    logic        acc_fr   [$];

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        logic [15:0] lo;
        lo = hw(a);
        if (lo[1:0] == 2'b11) return {hw(a + 32'd2), lo};
        return {16'h0000, lo};
    endfunction

    function automatic logic [31:0] exp_len(input logic [31:0] a);
        logic [15:0] lo;
        lo = hw(a);
        return (lo[1:0] == 2'b11) ? 32'd4 : 32'd2;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input logic [31:0] val);
        for (int i = 0; i < 256; i++) mem[i] = val;
    endtask

    task automatic do_reset(input int cycles);
        rst           = 1'b1;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        instr_ready_i = 1'b1;
        acc_n         = 0;
        acc_addr.delete();
        acc_data.delete();
        acc_fr.delete();
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    task automatic wait_acc(input int n, input string name);
        int budget;
        budget = 0;
        while (acc_n < n && budget < 200) begin
            tick();
            budget++;
        end
        check32(name, (acc_n >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_acc(input int idx, input logic [31:0] addr, input logic [31:0] data,
                             input string name);
        if (idx < acc_addr.size()) begin
            check32({name, "_addr"}, acc_addr[idx], addr);
            check32({name, "_data"}, acc_data[idx], data);
        end else begin
            check32({name, "_present"}, 32'd0, 32'd1);
        end
    endtask

    // Fetch side: a prefetch buffer serving sequential words from mem, optionally with gaps.
    initial begin
        int gcyc;
        gcyc          = 0;
        fetch_valid_i = 1'b0;
        fetch_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            gcyc++;
            fetch_rdata_i = mem[faddr[9:2]];
            fetch_valid_i = !(gap_en && (gcyc % 5 == 3));
        end
    end

    // Compare process and model update, away from the active edge.
    initial begin
        logic [31:0] len;
        forever begin
            @(negedge clk);
            if (rst) begin
                check32("valid_in_rst", {31'b0, instr_valid_o}, 32'd0);
                check32("fready_in_rst", {31'b0, fetch_ready_o}, 32'd0);
                mpc     = RESET_PC;
                faddr   = RESET_PC & 32'hFFFF_FFFC;
                started = 1'b1;
            end else if (started) begin
                check32("instr_addr", instr_addr_o, mpc);
                if (branch_i) begin
                    check32("valid_in_branch", {31'b0, instr_valid_o}, 32'd0);
                    check32("fready_in_branch", {31'b0, fetch_ready_o}, 32'd1);
                    mpc   = branch_addr_i & 32'hFFFF_FFFE;
                    faddr = branch_addr_i & 32'hFFFF_FFFC;
                end else begin
                    if (instr_valid_o) check32("instr_rdata", instr_rdata_o, exp_instr(mpc));
                    if (fetch_valid_i && fetch_ready_o) faddr = faddr + 32'd4;
                    if (instr_valid_o && instr_ready_i) begin
                        acc_addr.push_back(instr_addr_o);
                        acc_data.push_back(instr_rdata_o);
                        acc_fr.push_back(fetch_ready_o);
                        acc_n++;
                        len = exp_len(mpc);
                        mpc = mpc + len;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int cnt;
        rst           = 1'b1;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        instr_ready_i = 1'b1;

        // 1: two aligned 32-bit words
        fill_mem(NOP);
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        do_reset(2);
        wait_acc(2, "t1_progress");
        check_acc(0, 32'h0, 32'h0000_0013, "t1_i0");
        check_acc(1, 32'h4, 32'h0010_0093, "t1_i1");
        check32("t1_fr0", {31'b0, acc_fr[0]}, 32'd1);
        check32("t1_fr1", {31'b0, acc_fr[1]}, 32'd1);

        // 2: two compressed in one word
        fill_mem(NOP);
        mem[0] = 32'h0505_4501;
        do_reset(2);
        wait_acc(3, "t2_progress");
        check_acc(0, 32'h0, 32'h0000_4501, "t2_i0");
        check_acc(1, 32'h2, 32'h0000_0505, "t2_i1");
        check_acc(2, 32'h4, NOP, "t2_i2");
        check32("t2_fr0", {31'b0, acc_fr[0]}, 32'd1);
        check32("t2_fr1", {31'b0, acc_fr[1]}, 32'd0);

        // 3: straddling 32-bit instruction
        fill_mem(NOP);
        mem[0] = 32'h0513_4501;
        mem[1] = 32'h4585_00A0;
        do_reset(2);
        wait_acc(4, "t3_progress");
        check_acc(0, 32'h0, 32'h0000_4501, "t3_i0");
        check_acc(1, 32'h2, 32'h00A0_0513, "t3_i1");
        check_acc(2, 32'h6, 32'h0000_4585, "t3_i2");
        check_acc(3, 32'h8, NOP, "t3_i3");

        // 5: backpressure while the straddle is presented
        do_reset(2);
        tick();
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("t5_valid", {31'b0, instr_valid_o}, 32'd1);
            check32("t5_rdata", instr_rdata_o, 32'h00A0_0513);
            check32("t5_addr", instr_addr_o, 32'h2);
            check32("t5_fready", {31'b0, fetch_ready_o}, 32'd0);
            tick();
        end
        instr_ready_i = 1'b1;
        wait_acc(4, "t5_progress");
        cnt = 0;
        foreach (acc_addr[i]) if (acc_addr[i] == 32'h2) cnt++;
        check32("t5_accept_once", cnt, 32'd1);
        check_acc(2, 32'h6, 32'h0000_4585, "t5_i2");

        // 4 and 6a: branch to odd halfword with valid and ready high in the same cycle
        fill_mem(NOP);
        mem[8'h40] = 32'h0001_1234;
        do_reset(2);
        tick();
        tick();
        tick();
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_0102;
        @(negedge clk);
        check32("t4_fvalid_in_branch", {31'b0, fetch_valid_i}, 32'd1);
        check32("t4_ivalid_in_branch", {31'b0, instr_valid_o}, 32'd0);
        n0 = acc_n;
        tick();
        branch_i = 1'b0;
        check32("t6_no_accept_on_branch", acc_n, n0);
        @(negedge clk);
        check32("t4_bubble", {31'b0, instr_valid_o}, 32'd0);
        tick();
        @(negedge clk);
        check32("t4_valid", {31'b0, instr_valid_o}, 32'd1);
        check32("t4_rdata", instr_rdata_o, 32'h0000_0001);
        check32("t4_addr", instr_addr_o, 32'h0000_0102);
        wait_acc(n0 + 2, "t4_progress");
        check_acc(n0, 32'h102, 32'h0000_0001, "t4_i0");
        check_acc(n0 + 1, 32'h104, NOP, "t4_i1");

        // 6b: reset mid-straddle
        fill_mem(NOP);
        mem[0] = 32'h0513_4501;
        mem[1] = 32'h4585_00A0;
        do_reset(2);
        tick();
        check32("t6_mid_straddle_pc", instr_addr_o, 32'h2);
        do_reset(1);
        wait_acc(2, "t6_progress");
        check_acc(0, RESET_PC, 32'h0000_4501, "t6_i0");
        check_acc(1, 32'h2, 32'h00A0_0513, "t6_i1");

        // PC wrap with a straddle across the top of the address space
        fill_mem(NOP);
        mem[8'hFF] = 32'h0513_0000;
        mem[0]     = 32'h0000_00A0;
        do_reset(2);
        tick();
        branch_i      = 1'b1;
        branch_addr_i = 32'hFFFF_FFFE;
        tick();
        branch_i = 1'b0;
        n0 = acc_n;
        wait_acc(n0 + 2, "wrap_progress");
        check_acc(n0, 32'hFFFF_FFFE, 32'h00A0_0513, "wrap_i0");
        check_acc(n0 + 1, 32'h0000_0002, 32'h0000_0000, "wrap_i1");

        // Mixed stream with fetch gaps, backpressure and redirects; checked by the model
        for (int i = 0; i < 256; i++) mem[i] = 32'h9E37_79B9 * (i + 1);
        gap_en = 1'b1;
        do_reset(2);
        for (int c = 0; c < 300; c++) begin
            instr_ready_i = (c % 7 != 2);
            branch_i      = 1'b0;
            if (c == 60) begin
                branch_i      = 1'b1;
                branch_addr_i = 32'h0000_0103;
            end else if (c == 150) begin
                branch_i      = 1'b1;
                branch_addr_i = 32'hFFFF_FFF8;
            end else if (c == 220) begin
                branch_i      = 1'b1;
                branch_addr_i = 32'hFFFF_FFFE;
            end
            tick();
        end
        branch_i      = 1'b0;
        instr_ready_i = 1'b1;
        gap_en        = 1'b0;
        check32("stream_progress", (acc_n >= 80) ? 32'd1 : 32'd0, 32'd1);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
